aer_spike_encoder: RTL and testbench

AER_SPIKE_ENCODER -- requirements
Module: aer_spike_encoder

---
 rtl/aer_spike_encoder_pkg.sv | 34 +++
 rtl/aer_spike_encoder_if.sv | 23 ++
 rtl/aer_event_fifo.sv | 87 ++++++++
 rtl/aer_spike_encoder.sv | 153 +++++++++++++++
 tb/tb_aer_spike_encoder.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/aer_spike_encoder_pkg.sv
// -----------------------------------------------------------------------------
// aer_spike_encoder_pkg
// Shared constants and types for the AER spike encoder slice.
//   DEF_*        : default parameter values used by the encoder, its FIFO and
//                  the AER bus interface.
//   aer_event_t  : one address-event record {addr, ts} at default widths.
//   sat_add8     : saturating 8-bit accumulate used by the lost-spike counter.
// -----------------------------------------------------------------------------
package aer_spike_encoder_pkg;

    localparam int DEF_N_SRC      = 4;
    localparam int DEF_ADDR_W     = 2;
    localparam int DEF_TS_W       = 6;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DROP_W         = 8;

    // Event record as it travels through the queue: source index, then stamp.
    typedef struct packed {
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_TS_W-1:0]   ts;
    } aer_event_t;

    // Add a small increment to an 8-bit counter, pinning the result at 255.
    function automatic logic [7:0] sat_add8(input logic [7:0] base, input logic [3:0] inc);
        logic [8:0] sum;
        sum = {1'b0, base} + {5'b00000, inc};
        if (sum[8]) begin
            return 8'hFF;
        end else begin
            return sum[7:0];
        end
    endfunction

endpackage

// File: rtl/aer_spike_encoder_if.sv
// -----------------------------------------------------------------------------
// aer_spike_encoder_if
// Valid/ready address-event bus between the encoder and its consumer.
//   aer_valid : an event is presented (producer -> consumer)
//   aer_ready : consumer accepts the presented event (consumer -> producer)
//   aer_addr  : source index of the presented event
//   aer_time  : capture timestamp of the presented event
// Modports: master = event producer (encoder), slave = event consumer.
// -----------------------------------------------------------------------------
interface aer_spike_encoder_if
    import aer_spike_encoder_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int TS_W   = DEF_TS_W
);
    logic              aer_valid;
    logic              aer_ready;
    logic [ADDR_W-1:0] aer_addr;
    logic [TS_W-1:0]   aer_time;

    modport master (output aer_valid, output aer_addr, output aer_time, input aer_ready);
    modport slave  (input aer_valid, input aer_addr, input aer_time, output aer_ready);
endinterface

// File: rtl/aer_event_fifo.sv
// -----------------------------------------------------------------------------
// aer_event_fifo
// Small synchronous event queue with first-word-fall-through head.
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   push       : write push_data (honoured when not full, or full with a pop)
//   push_data  : event word {addr, ts}
//   pop_req    : consumer ready; a pop happens when pop_req and not empty
//   full/empty : occupancy flags
//   pop        : a pop happens on this edge
//   head       : oldest stored event
// -----------------------------------------------------------------------------
module aer_event_fifo
    import aer_spike_encoder_pkg::*;
#(
    parameter int DW    = DEF_ADDR_W + DEF_TS_W,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop_req,
    output logic          full,
    output logic          empty,
    output logic          pop,
    output logic [DW-1:0] head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

    logic [DW-1:0]    mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push_ok_s;

    assign empty     = (count_q == '0);
    assign full      = (count_q == DEPTH_C);
    assign pop       = pop_req && !empty;
    // A full queue still accepts a write when the head leaves on the same edge.
    assign push_ok_s = push && (!full || pop);
    assign head      = mem_q[rd_ptr_q];

    // Next-state for pointers and occupancy; power-of-two depth wraps naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/aer_spike_encoder.sv
// -----------------------------------------------------------------------------
// aer_spike_encoder
// Captures single-cycle spikes from N_SRC sources, stamps them with a free-
// running timestamp, arbitrates round-robin into an event queue and presents
// events on a valid/ready AER bus.
//   clk, reset  : rising-edge clock, asynchronous active-high reset
//   en          : capture enable; spikes are ignored while low
//   spike_in    : one spike pulse per source
//   aer         : AER bus (master side): valid/ready/addr/time
//   drop_count  : saturating count of spikes lost to a busy source slot
// -----------------------------------------------------------------------------
module aer_spike_encoder
    import aer_spike_encoder_pkg::*;
#(
    parameter int N_SRC      = DEF_N_SRC,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int TS_W       = DEF_TS_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [N_SRC-1:0]    spike_in,
    aer_spike_encoder_if.master aer,
    output logic [DROP_W-1:0]   drop_count
);

    localparam int EVT_W = ADDR_W + TS_W;

    logic [TS_W-1:0]   ts_q, ts_d;
    logic [N_SRC-1:0]  pending_q, pending_d;
    logic [TS_W-1:0]   ts_lat_q [N_SRC];
    logic [TS_W-1:0]   ts_lat_d [N_SRC];
    logic [ADDR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [7:0]        drop_count_q, drop_count_d;

    logic              can_push_s;
    logic              grant_vld_s;
    logic [ADDR_W-1:0] grant_idx_s;
    logic [N_SRC-1:0]  drops_s;
    logic [3:0]        drop_num_s;
    logic              fifo_full_s, fifo_empty_s, fifo_pop_s;
    logic [EVT_W-1:0]  fifo_head_s;
    logic [EVT_W-1:0]  push_data_s;

    // A slot may be granted only if the queue can take the event this edge.
    assign can_push_s = !fifo_full_s || fifo_pop_s;

    // Round-robin search of pending sources starting at rr_ptr.
    always_comb begin
        logic [ADDR_W-1:0] cand;
        grant_vld_s = 1'b0;
        grant_idx_s = rr_ptr_q;
        cand        = rr_ptr_q;
        for (int k = 0; k < N_SRC; k++) begin
            cand = rr_ptr_q + ADDR_W'(k);
            if (can_push_s && !grant_vld_s && pending_q[cand]) begin
                grant_vld_s = 1'b1;
                grant_idx_s = cand;
            end else begin
                grant_vld_s = grant_vld_s;
            end
        end
    end

    // Capture, drop detection, timestamp and pointer next-state.
    always_comb begin
        logic spk;
        logic gnt;
        ts_d      = ts_q + 1'b1;
        pending_d = pending_q;
        ts_lat_d  = ts_lat_q;
        drops_s   = '0;
        spk       = 1'b0;
        gnt       = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            spk = en && spike_in[i];
            gnt = grant_vld_s && (grant_idx_s == ADDR_W'(i));
            if (gnt) begin
                // Leaving slot is refilled by a same-edge spike; no loss.
                pending_d[i] = spk;
                if (spk) begin
                    ts_lat_d[i] = ts_q;
                end else begin
                    ts_lat_d[i] = ts_lat_q[i];
                end
            end else if (spk && pending_q[i]) begin
                drops_s[i] = 1'b1;
            end else if (spk) begin
                pending_d[i] = 1'b1;
                ts_lat_d[i]  = ts_q;
            end else begin
                pending_d[i] = pending_q[i];
            end
        end

        drop_num_s = 4'd0;
        for (int i = 0; i < N_SRC; i++) begin
            drop_num_s = drop_num_s + {3'b000, drops_s[i]};
        end
        drop_count_d = sat_add8(drop_count_q, drop_num_s);

        if (grant_vld_s) begin
            rr_ptr_d = grant_idx_s + 1'b1;
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Encoder state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_q         <= '0;
            pending_q    <= '0;
            rr_ptr_q     <= '0;
            drop_count_q <= 8'd0;
            for (int i = 0; i < N_SRC; i++) begin
                ts_lat_q[i] <= '0;
            end
        end else begin
            ts_q         <= ts_d;
            pending_q    <= pending_d;
            rr_ptr_q     <= rr_ptr_d;
            drop_count_q <= drop_count_d;
            for (int i = 0; i < N_SRC; i++) begin
                ts_lat_q[i] <= ts_lat_d[i];
            end
        end
    end

    assign push_data_s = {grant_idx_s, ts_lat_q[grant_idx_s]};

    aer_event_fifo #(
        .DW    (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (grant_vld_s),
        .push_data (push_data_s),
        .pop_req   (aer.aer_ready),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .pop       (fifo_pop_s),
        .head      (fifo_head_s)
    );

    assign aer.aer_valid = !fifo_empty_s;
    assign aer.aer_addr  = fifo_head_s[EVT_W-1:TS_W];
    assign aer.aer_time  = fifo_head_s[TS_W-1:0];
    assign drop_count    = drop_count_q;

endmodule

// File: tb/tb_aer_spike_encoder.sv
module tb_aer_spike_encoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [3:0] spike_in;
    logic [7:0] drop_count;
    int         chk_cnt  = 0;
    int         pass_cnt = 0;
    int         tb_ts    = 0;

    aer_spike_encoder_if #(.ADDR_W(2), .TS_W(6)) aer ();

    aer_spike_encoder #(
        .N_SRC(4), .ADDR_W(2), .TS_W(6), .FIFO_DEPTH(4)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .spike_in   (spike_in),
        .aer        (aer),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        tb_ts = (tb_ts + 1) % 64;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        en            = 1'b1;
        spike_in      = 4'b0000;
        aer.aer_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        tb_ts = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b1; spike_in = 4'b0000; aer.aer_ready = 1'b0;
        #1;
        chk_cnt++; if (aer.aer_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", aer.aer_valid); else pass_cnt++;
        chk_cnt++; if (drop_count !== 8'd0) $display("FAIL reset_drop: got %0d want 0", drop_count); else pass_cnt++;
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        aer.aer_ready = 1'b1;
        repeat (5) step();
        spike_in = 4'b0010;
        step();
        spike_in = 4'b0000;
        chk_cnt++; if (aer.aer_valid !== 1'b0) $display("FAIL single_e0_valid: got %b want 0", aer.aer_valid); else pass_cnt++;
        step();
        chk_cnt++; if (aer.aer_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", aer.aer_valid); else pass_cnt++;
        chk_cnt++; if (aer.aer_addr !== 2'd1) $display("FAIL single_addr: got %0d want 1", aer.aer_addr); else pass_cnt++;
        chk_cnt++; if (aer.aer_time !== 6'd5) $display("FAIL single_time: got %0d want 5", aer.aer_time); else pass_cnt++;
        step();
        chk_cnt++; if (aer.aer_valid !== 1'b0) $display("FAIL single_popped: got %b want 0", aer.aer_valid); else pass_cnt++;
    endtask

    task automatic test_round_robin();
        int t0;
        do_reset();
        aer.aer_ready = 1'b1;
        repeat (3) step();
        t0 = tb_ts;
        spike_in = 4'b1111;
        step();
        spike_in = 4'b0000;
        step();
        for (int i = 0; i < 4; i++) begin
            chk_cnt++; if (aer.aer_valid !== 1'b1) $display("FAIL rr_valid[%0d]: got %b want 1", i, aer.aer_valid); else pass_cnt++;
            chk_cnt++; if (aer.aer_addr !== 2'(i)) $display("FAIL rr_addr[%0d]: got %0d want %0d", i, aer.aer_addr, i); else pass_cnt++;
            chk_cnt++; if (aer.aer_time !== 6'(t0)) $display("FAIL rr_time[%0d]: got %0d want %0d", i, aer.aer_time, t0); else pass_cnt++;
            step();
        end
        chk_cnt++; if (aer.aer_valid !== 1'b0) $display("FAIL rr_drained: got %b want 0", aer.aer_valid); else pass_cnt++;
        chk_cnt++; if (drop_count !== 8'd0) $display("FAIL rr_drop: got %0d want 0", drop_count); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [1:0] src [6];
        int         tsv [6];
        src = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        do_reset();
        aer.aer_ready = 1'b0;
        repeat (2) step();
        for (int k = 0; k < 6; k++) begin
            spike_in = 4'b0001 << src[k];
            tsv[k]   = tb_ts;
            step();
        end
        spike_in = 4'b0000;
        repeat (2) step();
        chk_cnt++; if (aer.aer_valid !== 1'b1) $display("FAIL bp_valid: got %b want 1", aer.aer_valid); else pass_cnt++;
        chk_cnt++; if (aer.aer_addr !== 2'd0 || aer.aer_time !== 6'(tsv[0])) $display("FAIL bp_head: got %0d/%0d want 0/%0d", aer.aer_addr, aer.aer_time, tsv[0]); else pass_cnt++;
        repeat (3) step();
        chk_cnt++; if (aer.aer_valid !== 1'b1 || aer.aer_addr !== 2'd0 || aer.aer_time !== 6'(tsv[0])) $display("FAIL bp_stable: got %b %0d/%0d want 1 0/%0d", aer.aer_valid, aer.aer_addr, aer.aer_time, tsv[0]); else pass_cnt++;
        aer.aer_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            chk_cnt++; if (aer.aer_valid !== 1'b1 || aer.aer_addr !== src[k] || aer.aer_time !== 6'(tsv[k])) $display("FAIL bp_evt[%0d]: got %b %0d/%0d want 1 %0d/%0d", k, aer.aer_valid, aer.aer_addr, aer.aer_time, src[k], tsv[k]); else pass_cnt++;
            step();
        end
        chk_cnt++; if (aer.aer_valid !== 1'b0) $display("FAIL bp_drained: got %b want 0", aer.aer_valid); else pass_cnt++;
        chk_cnt++; if (drop_count !== 8'd0) $display("FAIL bp_drop: got %0d want 0", drop_count); else pass_cnt++;
    endtask

    task automatic test_drop();
        int tf;
        do_reset();
        aer.aer_ready = 1'b0;
        step();
        for (int s = 0; s < 4; s++) begin
            spike_in = 4'b0001 << s;
            step();
        end
        spike_in = 4'b0001;
        tf = tb_ts;
        step();
        repeat (3) begin
            spike_in = 4'b0001;
            step();
        end
        spike_in = 4'b0000;
        chk_cnt++; if (drop_count !== 8'd3) $display("FAIL drop_count3: got %0d want 3", drop_count); else pass_cnt++;
        aer.aer_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk_cnt++; if (aer.aer_valid !== 1'b1 || aer.aer_addr !== 2'(k)) $display("FAIL drop_evt[%0d]: got %b %0d want 1 %0d", k, aer.aer_valid, aer.aer_addr, k); else pass_cnt++;
            step();
        end
        chk_cnt++; if (aer.aer_valid !== 1'b1 || aer.aer_addr !== 2'd0 || aer.aer_time !== 6'(tf)) $display("FAIL drop_first_ts: got %b %0d/%0d want 1 0/%0d", aer.aer_valid, aer.aer_addr, aer.aer_time, tf); else pass_cnt++;
        step();
        chk_cnt++; if (aer.aer_valid !== 1'b0) $display("FAIL drop_drained: got %b want 0", aer.aer_valid); else pass_cnt++;
    endtask

    task automatic test_wrap();
        do_reset();
        aer.aer_ready = 1'b1;
        while (tb_ts != 63) step();
        spike_in = 4'b0100;
        step();
        spike_in = 4'b0100;
        step();
        spike_in = 4'b0000;
        chk_cnt++; if (aer.aer_valid !== 1'b1 || aer.aer_addr !== 2'd2 || aer.aer_time !== 6'd63) $display("FAIL wrap_first: got %b %0d/%0d want 1 2/63", aer.aer_valid, aer.aer_addr, aer.aer_time); else pass_cnt++;
        step();
        chk_cnt++; if (aer.aer_valid !== 1'b1 || aer.aer_addr !== 2'd2 || aer.aer_time !== 6'd0) $display("FAIL wrap_second: got %b %0d/%0d want 1 2/0", aer.aer_valid, aer.aer_addr, aer.aer_time); else pass_cnt++;
        step();
        chk_cnt++; if (aer.aer_valid !== 1'b0) $display("FAIL wrap_drained: got %b want 0", aer.aer_valid); else pass_cnt++;
        chk_cnt++; if (drop_count !== 8'd0) $display("FAIL wrap_drop: got %0d want 0", drop_count); else pass_cnt++;
    endtask

    task automatic test_saturate();
        do_reset();
        aer.aer_ready = 1'b0;
        spike_in = 4'b1111;
        step();
        chk_cnt++; if (drop_count !== 8'd0) $display("FAIL sat_e1: got %0d want 0", drop_count); else pass_cnt++;
        step();
        chk_cnt++; if (drop_count !== 8'd3) $display("FAIL sat_multi: got %0d want 3", drop_count); else pass_cnt++;
        repeat (4) step();
        chk_cnt++; if (drop_count !== 8'd16) $display("FAIL sat_16: got %0d want 16", drop_count); else pass_cnt++;
        repeat (80) step();
        spike_in = 4'b0000;
        chk_cnt++; if (drop_count !== 8'd255) $display("FAIL sat_255: got %0d want 255", drop_count); else pass_cnt++;
    endtask

    task automatic test_enable();
        int t1;
        do_reset();
        aer.aer_ready = 1'b0;
        step();
        t1 = tb_ts;
        spike_in = 4'b1000;
        step();
        en = 1'b0;
        spike_in = 4'b1111;
        repeat (3) step();
        spike_in = 4'b0000;
        en = 1'b1;
        chk_cnt++; if (drop_count !== 8'd0) $display("FAIL en_drop: got %0d want 0", drop_count); else pass_cnt++;
        chk_cnt++; if (aer.aer_valid !== 1'b1 || aer.aer_addr !== 2'd3 || aer.aer_time !== 6'(t1)) $display("FAIL en_drain: got %b %0d/%0d want 1 3/%0d", aer.aer_valid, aer.aer_addr, aer.aer_time, t1); else pass_cnt++;
        aer.aer_ready = 1'b1;
        step();
        step();
        chk_cnt++; if (aer.aer_valid !== 1'b0) $display("FAIL en_ignored: got %b want 0", aer.aer_valid); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int t2;
        do_reset();
        aer.aer_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            spike_in = 4'b0001 << s;
            step();
        end
        spike_in = 4'b1000;
        step();
        spike_in = 4'b0000;
        chk_cnt++; if (aer.aer_valid !== 1'b1) $display("FAIL rst_mid_pre: got %b want 1", aer.aer_valid); else pass_cnt++;
        reset = 1'b1;
        #1;
        chk_cnt++; if (aer.aer_valid !== 1'b0) $display("FAIL rst_mid_valid: got %b want 0", aer.aer_valid); else pass_cnt++;
        step();
        step();
        reset = 1'b0;
        tb_ts = 0;
        aer.aer_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk_cnt++; if (aer.aer_valid !== 1'b0) $display("FAIL rst_mid_replay[%0d]: got %b want 0", k, aer.aer_valid); else pass_cnt++;
        end
        t2 = tb_ts;
        spike_in = 4'b0001;
        step();
        spike_in = 4'b0000;
        step();
        chk_cnt++; if (aer.aer_valid !== 1'b1 || aer.aer_addr !== 2'd0 || aer.aer_time !== 6'(t2)) $display("FAIL rst_mid_new: got %b %0d/%0d want 1 0/%0d", aer.aer_valid, aer.aer_addr, aer.aer_time, t2); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_back_to_back();
        test_drop();
        test_wrap();
        test_saturate();
        test_enable();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
